// File: rtl/dcache_flush_walker.sv
// Write-back DCache flush sequencer: walks every set, issues write-backs for dirty lines,
// invalidates each set, then acknowledges once all accepted write-backs have completed.
module dcache_flush_walker #(
  parameter int NUM_SETS     = 256,
  parameter int NUM_WAYS     = 8,
  parameter int MAX_WB_OUTST = 4,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  output logic                tag_req_o,
  input  logic                tag_gnt_i,
  output logic [IDX_W-1:0]    tag_idx_o,
  input  logic [NUM_WAYS-1:0] tag_valid_i,
  input  logic [NUM_WAYS-1:0] tag_dirty_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [IDX_W-1:0]    wb_idx_o,
  output logic [WAY_W-1:0]    wb_way_o,
  input  logic                wb_done_i,
  output logic                inv_req_o
);

  localparam int OUT_W = $clog2(MAX_WB_OUTST + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WB, S_INV, S_DRAIN, S_ACK
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    set_reg, set_next;
  logic [NUM_WAYS-1:0] mask_reg, mask_next;
  logic [OUT_W-1:0]    outst_reg, outst_next;
  logic                armed_reg, armed_next;
  logic [WAY_W-1:0]    low_way;
  logic                wb_accept;
  logic                wb_retire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      set_reg   <= '0;
      mask_reg  <= '0;
      outst_reg <= '0;
      armed_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      set_reg   <= set_next;
      mask_reg  <= mask_next;
      outst_reg <= outst_next;
      armed_reg <= armed_next;
    end
  end

  // Lowest set bit wins, so write-backs of a set leave in ascending way order.
  always_comb begin
    low_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (mask_reg[i]) low_way = WAY_W'(i);
    end
  end

  assign wb_valid_o = (state_reg == S_WB) && (outst_reg < OUT_W'(MAX_WB_OUTST));
  assign wb_accept  = wb_valid_o && wb_ready_i;
  assign wb_retire  = wb_done_i && (outst_reg != '0);
  assign wb_idx_o   = set_reg;
  assign wb_way_o   = low_way;
  assign tag_idx_o  = set_reg;
  assign busy_o     = (state_reg != S_IDLE);

  always_comb begin
    outst_next = outst_reg;
    if (wb_accept && !wb_retire)      outst_next = outst_reg + OUT_W'(1);
    else if (!wb_accept && wb_retire) outst_next = outst_reg - OUT_W'(1);
  end

  always_comb begin
    state_next  = state_reg;
    set_next    = set_reg;
    mask_next   = mask_reg;
    armed_next  = armed_reg;
    tag_req_o   = 1'b0;
    inv_req_o   = 1'b0;
    flush_ack_o = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!flush_i) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next = S_READ;
          set_next   = '0;
        end
      end
      S_READ: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        mask_next  = tag_valid_i & tag_dirty_i;
        state_next = (|(tag_valid_i & tag_dirty_i)) ? S_WB : S_INV;
      end
      S_WB: begin
        if (wb_accept) begin
          // Clearing the lowest set bit retires exactly the way just accepted.
          mask_next = mask_reg & (mask_reg - NUM_WAYS'(1));
          if ((mask_reg & (mask_reg - NUM_WAYS'(1))) == '0) state_next = S_INV;
        end
      end
      S_INV: begin
        inv_req_o = 1'b1;
        if (set_reg == IDX_W'(NUM_SETS - 1)) begin
          state_next = S_DRAIN;
        end else begin
          set_next   = set_reg + IDX_W'(1);
          state_next = S_READ;
        end
      end
      S_DRAIN: begin
        if (outst_reg == '0) begin
          state_next = S_ACK;
          armed_next = 1'b0;
        end
      end
      S_ACK: begin
        flush_ack_o = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  a_done_has_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) wb_done_i |-> (outst_reg != '0));

endmodule

// File: doc/dcache_flush_walker.md
Name: dcache_flush_walker

Overview:
- Write-back DCache flush sequencer; sits directly downstream of the flush controller.
- Consumes the registered flush_dcache request and returns the single-cycle flush acknowledge that releases the fence halt.
- Walks every set. Reads tag/valid/dirty for all ways, issues write-backs for dirty lines, then invalidates the set.
- Acknowledges only after all write-backs have completed.

Parameters:
- NUM_SETS, 256, number of cache sets; power of two, >=2.
- NUM_WAYS, 8, associativity; >=1.
- MAX_WB_OUTST, 4, maximum write-backs in flight; >=1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  flush request level; held high until flush_ack_o
- flush_ack_o  out  1  one-cycle pulse; flush complete
- busy_o  out  1  high whenever FSM not IDLE; cache blocks new core requests
- tag_req_o  out  1  tag array read request
- tag_gnt_i  in  1  tag read accepted this cycle
- tag_idx_o  out  $clog2(NUM_SETS)  set index for tag read and invalidate
- tag_valid_i  in  NUM_WAYS  per-way valid; valid exactly one cycle after grant
- tag_dirty_i  in  NUM_WAYS  per-way dirty; same timing as tag_valid_i
- wb_valid_o  out  1  write-back request
- wb_ready_i  in  1  write-back unit accepts
- wb_idx_o  out  $clog2(NUM_SETS)  write-back set
- wb_way_o  out  $clog2(NUM_WAYS) (min 1)  write-back way
- wb_done_i  in  1  one write-back finished (pulse; one per accepted request)
- inv_req_o  out  1  invalidate all ways of set tag_idx_o; always accepted in one cycle

Behaviour:
- Reset: state IDLE, set counter 0, dirty mask 0, outstanding counter 0. All outputs 0.
- IDLE:
  - flush_i=1 and armed -> READ, set counter=0.
  - armed clears on entry to ACK; re-sets when flush_i is sampled 0 in IDLE. A level still high after ack never restarts a walk.
- READ: tag_req_o=1, tag_idx_o=counter; hold until tag_gnt_i, then -> CAPTURE.
- CAPTURE (1 cycle):
  - Latch dirty mask = tag_valid_i & tag_dirty_i.
  - Mask nonzero -> WB; else -> INV.
- WB:
  - wb_way_o = lowest set bit of dirty mask; wb_idx_o = counter.
  - wb_valid_o=1 only while outstanding < MAX_WB_OUTST.
  - On wb_valid_o & wb_ready_i: clear that bit, outstanding+1.
  - Mask becomes 0 -> INV.
  - wb_valid_o/idx/way stay stable until accepted (valid/ready rule; no retraction).
- INV (1 cycle): inv_req_o=1, tag_idx_o=counter.
  - Counter == NUM_SETS-1 -> DRAIN; else counter+1 -> READ.
- DRAIN: wait for outstanding == 0 -> ACK.
- ACK (1 cycle): flush_ack_o=1 -> IDLE.
- Outstanding counter, any state:
  - Increments on accept, decrements on wb_done_i.
  - Same cycle: unchanged.
  - wb_done_i with outstanding 0 is ignored (assertion in sim).
- Invalidation of a set may precede completion of its write-backs: the write-back unit owns the line data once accepted.
- flush_i deasserting mid-walk is ignored; the walk completes and acks (the controller keeps the request high anyway).
- Reset mid-walk: immediate return to IDLE, all counters cleared, no ack issued.
- Latency with no dirty lines and immediate grants: 3 cycles per set + 1 DRAIN + 1 ACK, i.e. 3*NUM_SETS+2 cycles from flush_i to flush_ack_o.
- busy_o=1 in every state except IDLE.

Test Plan:
- NUM_SETS=4, NUM_WAYS=2, all lines clean, tag_gnt_i tied 1:
  - flush_i rises at cycle 0 -> inv_req_o pulses for idx 0,1,2,3, no wb_valid_o, flush_ack_o at cycle 14.
  - busy_o high cycles 1..14.
- Set 2 way 1 dirty, wb_ready_i=1, wb_done_i 5 cycles after accept:
  - Exactly one write-back with idx=2, way=1.
  - DRAIN holds until wb_done_i; ack one cycle later.
- All 8 lines dirty, MAX_WB_OUTST=2, wb_done_i withheld:
  - After 2 accepts, wb_valid_o stays 0.
  - Each wb_done_i releases exactly one more; total 8 write-backs in way order 0,1 per set.
- tag_gnt_i low for 3 cycles at set 1:
  - tag_req_o held with idx=1 throughout.
  - Walk resumes; all 4 invalidates occur, each exactly once.
- flush_i held high 5 cycles after flush_ack_o:
  - No second walk.
  - flush_i 0 for 1 cycle, then 1 -> new walk starts at set 0.
- rst_ni asserted during WB of set 1 with outstanding=1:
  - Outputs 0 immediately; no ack.
  - Next flush_i restarts at set 0 with outstanding 0.
